// File: rtl/i3c_sdr_hdr_ctrl_if.sv
// Request/status handshake plus the push-pull SCL line of the I3C SDR header engine.
// SDA stays a plain inout on the engine because it is a resolved open-drain net.
interface i3c_sdr_hdr_ctrl_if;
  logic       start_req;
  logic [6:0] tgt_addr;
  logic       tgt_rw;
  logic       busy;
  logic       done;
  logic       nack_bcast;
  logic       nack_tgt;
  logic       scl;

  // Handshake: start_req is accepted on a clock edge only while busy==0 and done==0;
  // busy then stays high until the single-cycle done pulse, when the nack flags are valid.
  modport master (
    input  start_req, tgt_addr, tgt_rw,
    output busy, done, nack_bcast, nack_tgt, scl
  );

  modport slave (
    output start_req, tgt_addr, tgt_rw,
    input  busy, done, nack_bcast, nack_tgt, scl
  );
endinterface

// File: rtl/i3c_sdr_hdr_ctrl.sv
// Controller-side I3C SDR header engine: START, 7E+W, ACK, Sr, addr+RW, ACK, STOP.
// SCL is push-pull; SDA is open-drain and is only ever pulled low or released.
module i3c_sdr_hdr_ctrl #(
  parameter int         CLK_DIV        = 4,
  parameter logic [6:0] BROADCAST_ADDR = 7'h7E
) (
  input  logic                   clk,
  input  logic                   rst,
  i3c_sdr_hdr_ctrl_if.master     ctl,
  inout  wire                    sda,
  output logic [3:0]             state_dbg
);
  localparam int HCW = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    IDLE, START, BCAST, ACK1, RSTART, ADDR, ACK2, STOP, DONE
  } state_t;

  state_t     state, state_nx;
  logic [HCW-1:0] hc;
  logic [1:0] ph, ph_nx;
  logic [2:0] bit_cnt, bit_nx;
  logic [6:0] addr_q;
  logic       rw_q;
  logic       nack_bcast_q, nack_tgt_q;
  logic       accept, set_nb, set_nt;
  logic       phase_end, sda_low, scl_o, cur_bit;
  logic [7:0] hdr;

  assign phase_end = (hc == HCW'(CLK_DIV - 1));
  assign hdr       = (state == BCAST) ? {BROADCAST_ADDR, 1'b0} : {addr_q, rw_q};
  assign cur_bit   = hdr[3'd7 - bit_cnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hc           <= '0;
      ph           <= '0;
      bit_cnt      <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      nack_bcast_q <= 1'b0;
      nack_tgt_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      ph      <= ph_nx;
      bit_cnt <= bit_nx;
      if (state == IDLE || state == DONE || phase_end) hc <= '0;
      else                                             hc <= hc + 1'b1;
      if (accept) begin
        addr_q       <= ctl.tgt_addr;
        rw_q         <= ctl.tgt_rw;
        nack_bcast_q <= 1'b0;
        nack_tgt_q   <= 1'b0;
      end else begin
        if (set_nb) nack_bcast_q <= 1'b1;
        if (set_nt) nack_tgt_q   <= 1'b1;
      end
    end
  end

  // ph is the half-period index inside the current slot (bit slots: 0 low, 1 high).
  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    bit_nx   = bit_cnt;
    accept   = 1'b0;
    set_nb   = 1'b0;
    set_nt   = 1'b0;
    scl_o    = 1'b1;
    sda_low  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctl.start_req) begin
          accept   = 1'b1;
          state_nx = START;
          ph_nx    = 2'd0;
          bit_nx   = 3'd0;
        end
      end
      START: begin
        sda_low = 1'b1;
        if (phase_end) state_nx = BCAST;
      end
      BCAST, ADDR: begin
        scl_o   = ph[0];
        sda_low = ~cur_bit;
        if (phase_end) begin
          if (ph == 2'd0) ph_nx = 2'd1;
          else begin
            ph_nx  = 2'd0;
            bit_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nx = (state == BCAST) ? ACK1 : ACK2;
          end
        end
      end
      ACK1, ACK2: begin
        scl_o = ph[0];
        if (phase_end) begin
          if (ph == 2'd0) ph_nx = 2'd1;
          else begin
            ph_nx = 2'd0;
            // Released SDA reads as 1 through the pull-up: that is a NACK.
            if (state == ACK1) begin
              state_nx = sda ? STOP : RSTART;
              set_nb   = sda;
            end else begin
              state_nx = STOP;
              set_nt   = sda;
            end
          end
        end
      end
      RSTART: begin
        scl_o   = (ph != 2'd0);
        sda_low = (ph == 2'd2);
        if (phase_end) begin
          if (ph == 2'd2) begin
            state_nx = ADDR;
            ph_nx    = 2'd0;
            bit_nx   = 3'd0;
          end else ph_nx = ph + 2'd1;
        end
      end
      STOP: begin
        scl_o   = (ph != 2'd0);
        sda_low = (ph != 2'd2);
        if (phase_end) begin
          if (ph == 2'd2) begin
            state_nx = DONE;
            ph_nx    = 2'd0;
          end else ph_nx = ph + 2'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sda            = sda_low ? 1'b0 : 1'bz;
  assign ctl.scl        = scl_o;
  assign ctl.busy       = (state != IDLE) && (state != DONE);
  assign ctl.done       = (state == DONE);
  assign ctl.nack_bcast = nack_bcast_q;
  assign ctl.nack_tgt   = nack_tgt_q;
  assign state_dbg      = state;
endmodule

// File: tb/tb_i3c_sdr_hdr_ctrl.sv
// Randomized bench for i3c_sdr_hdr_ctrl: a bus-level target model answers the headers,
// the driver queues expected results, and a negedge monitor compares them at done.
module tb_i3c_sdr_hdr_ctrl;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] state_dbg;
  wire sda;
  i3c_sdr_hdr_ctrl_if ifc ();

  i3c_sdr_hdr_ctrl #(.CLK_DIV(CLK_DIV), .BROADCAST_ADDR(7'h7E)) dut (
    .clk(clk), .rst(rst), .ctl(ifc.master), .sda(sda), .state_dbg(state_dbg)
  );

  // Open-drain bus: pull-up plus the target's ACK pull-down.
  logic tgt_low = 1'b0;
  pullup (sda);
  assign sda = tgt_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {done_cycle[15:0], ack0, addr[6:0], rw, nack_bcast, nack_tgt}
  localparam int W = 27;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_e = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] ack_cfg = 2'b00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- monitor + target model ----------------
  logic scl_p = 1'b1, sda_p = 1'b1, rst_prev = 1'b0;
  int   starts = 0, stops = 0, bitn = 0, pend = 0, post = 0;
  logic [7:0] hdr0 = '0, hdr1 = '0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_prev) begin
      chk("rst_scl",   32'(ifc.scl), 32'd1);
      chk("rst_sda",   32'(sda), 32'd1);
      chk("rst_busy",  32'(ifc.busy), 32'd0);
      chk("rst_done",  32'(ifc.done), 32'd0);
      chk("rst_nackb", 32'(ifc.nack_bcast), 32'd0);
      chk("rst_nackt", 32'(ifc.nack_tgt), 32'd0);
      exp_q.delete();
      starts = 0; stops = 0; bitn = 0; pend = 0; post = 0;
      tgt_low = 1'b0;
    end else begin
      if (scl_p && ifc.scl && sda_p && !sda) begin
        starts++;
        bitn = 0;
      end
      if (scl_p && ifc.scl && !sda_p && sda) stops++;
      if (!scl_p && ifc.scl) begin
        if (bitn < 8 && starts == 1) hdr0[7-bitn] = sda;
        if (bitn < 8 && starts == 2) hdr1[7-bitn] = sda;
        bitn++;
      end
      if (scl_p && !ifc.scl) begin
        if (bitn == 8 && (starts == 1 || starts == 2) && ack_cfg[starts-1]) tgt_low = 1'b1;
        if (bitn == 9) tgt_low = 1'b0;
      end

      if (exp_q.size() > 0) pend++;
      if (ifc.done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'(ifc.done), 32'd0);
        else begin
          e = exp_q.pop_front();
          last_e = e;
          pend = 0;
          chk("done_cycle", 32'(cyc[15:0]), 32'(e[26:11]));
          chk("nack_bcast", 32'(ifc.nack_bcast), 32'(e[1]));
          chk("nack_tgt",   32'(ifc.nack_tgt), 32'(e[0]));
          chk("hdr_bcast",  32'(hdr0), 32'h0000_00FC);
          if (e[10]) chk("hdr_tgt", 32'(hdr1), 32'(e[9:2]));
          chk("start_cnt",  32'(starts), e[10] ? 32'd2 : 32'd1);
          chk("stop_cnt",   32'(stops), 32'd1);
          post = 3;
        end
        starts = 0; stops = 0;
      end else if (pend > 200) begin
        chk("done_timeout", 32'(ifc.done), 32'd1);
        void'(exp_q.pop_front());
        pend = 0;
      end

      if (post > 0) begin
        post--;
        if (post == 0) begin
          chk("idle_scl",   32'(ifc.scl), 32'd1);
          chk("idle_sda",   32'(sda), 32'd1);
          chk("idle_busy",  32'(ifc.busy), 32'd0);
          chk("held_nackb", 32'(ifc.nack_bcast), 32'(last_e[1]));
          chk("held_nackt", 32'(ifc.nack_tgt), 32'(last_e[0]));
        end
      end
    end
    scl_p    = ifc.scl;
    sda_p    = sda;
    rst_prev = rst;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] a, input logic rw, input logic [1:0] ack);
    int n = 0;
    int phases;
    int acc;
    while ((ifc.busy || ifc.done) && n < 300) begin
      tick();
      n++;
    end
    ack_cfg       = ack;
    ifc.tgt_addr  = a;
    ifc.tgt_rw    = rw;
    ifc.start_req = 1'b1;
    tick();
    ifc.start_req = 1'b0;
    acc = cyc;
    // START + 9 bit slots + STOP; an ACKed broadcast adds Sr + 9 more bit slots.
    phases = 1 + 9 * 2 + 3;
    if (ack[0]) phases += 3 + 9 * 2;
    exp_q.push_back({16'(acc + phases * CLK_DIV), ack[0], a, rw, ~ack[0], ack[0] & ~ack[1]});
  endtask

  task automatic wait_done(input bit pulse);
    int n = 0;
    while (!ifc.done && n < 260) begin
      if (pulse) begin
        ifc.start_req = 1'($urandom_range(0, 1));
        ifc.tgt_addr  = 7'($urandom);
        ifc.tgt_rw    = 1'($urandom);
      end
      tick();
      n++;
    end
    // In pulse mode this request lands in the DONE cycle and must be ignored.
    if (pulse) ifc.start_req = 1'b1;
    tick();
    ifc.start_req = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    ifc.start_req = 1'b0;
    ifc.tgt_addr  = '0;
    ifc.tgt_rw    = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    issue(7'h12, 1'b0, 2'b00);
    wait_done(1'b0);
    issue(7'h2A, 1'b1, 2'b11);
    wait_done(1'b0);
    issue(7'h55, 1'b0, 2'b01);
    wait_done(1'b0);
    issue(7'h33, 1'b1, 2'b11);
    wait_done(1'b1);

    // Abort in the low phase of target-header bit 3.
    issue(7'h6C, 1'b0, 2'b11);
    begin
      int acc_c = cyc;
      while (cyc < acc_c + 28 * CLK_DIV) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    issue(7'h2A, 1'b1, 2'b11);
    wait_done(1'b0);

    for (int i = 0; i < 8; i++) begin
      issue(7'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
      wait_done(i[0]);
    end

    repeat (10) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
